mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/bus_pkg.sv | 27 ++
 rtl/mem_bus_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bus_pkg
// Description : Shared types for the SRAM-like memory bus. Holds the arbiter
//               state enum, the bus owner enum and the access size encoding
//               used by memsel (byte/half/word = 0/1/2).
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam logic [1:0] c_size_byte = 2'd0;
  localparam logic [1:0] c_size_half = 2'd1;
  localparam logic [1:0] c_size_word = 2'd2;

endpackage : bus_pkg
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Arbitrates the instruction-fetch and MEM-stage data
//               requesters onto one SRAM-like bus, one transaction at a time.
//               Data wins ties unless the fetch side has been passed over
//               STARVE_MAX consecutive times. A flush cancels the response
//               of an in-flight fetch without aborting the bus transaction.
// Ports       : clk, rst          - clock, async active-high reset
//               inst_*            - fetch requester (req/addr in, ok/rdata out)
//               data_*            - data requester (req/wr/size/addr/wdata in,
//                                   ok/rdata out)
//               flush             - cancels the pending fetch response
//               busy              - high while a transaction is in flight
//               bus_*             - SRAM-like master port
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data (MEM stage)
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // control
  input  logic        flush,
  output logic        busy,
  // SRAM-like bus
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  localparam int c_cnt_w = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_MAX);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  owner_t              r_owner;
  logic                r_wr;
  logic [1:0]          r_size;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [c_cnt_w-1:0]  r_starve;
  logic                r_drop;

  logic w_force_inst;
  logic w_grant_data;
  logic w_grant_inst;

  // Fetch is forced only when it could actually be granted (no flush).
  // Grants are masked during reset so no addr_ok can leak out while rst=1.
  assign w_force_inst = inst_req & data_req & ~flush & (r_starve == c_starve_max);
  assign w_grant_data = (r_state == ST_IDLE) & ~rst & data_req & ~w_force_inst;
  assign w_grant_inst = (r_state == ST_IDLE) & ~rst & inst_req & ~flush & ~w_grant_data;

  // Response data is a straight passthrough; the *_data_ok strobes qualify it.
  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

  assign busy      = (r_state != ST_IDLE);
  assign bus_wr    = r_wr;
  assign bus_size  = r_size;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    bus_req      = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_data) begin
          data_addr_ok = 1'b1;
          w_state_nxt  = ST_REQ;
        end else if (w_grant_inst) begin
          inst_addr_ok = 1'b1;
          w_state_nxt  = ST_REQ;
        end
      end
      ST_REQ: begin
        bus_req = 1'b1;
        if (bus_addr_ok) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus_data_ok) begin
          w_state_nxt = ST_IDLE;
          if (r_owner == OWN_DATA) begin
            data_data_ok = 1'b1;
          end else begin
            // A flush landing in the completion cycle also cancels the fetch.
            inst_data_ok = ~(r_drop | flush);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Owner, latched request fields, starvation counter and drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner  <= OWN_INST;
      r_wr     <= 1'b0;
      r_size   <= 2'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_starve <= '0;
      r_drop   <= 1'b0;
    end else begin
      if (w_grant_data) begin
        r_owner <= OWN_DATA;
        r_wr    <= data_wr;
        r_size  <= data_size;
        r_addr  <= data_addr;
        r_wdata <= data_wdata;
        if (!inst_req) begin
          r_starve <= '0;
        end else if (r_starve != c_starve_max) begin
          r_starve <= r_starve + 1'b1;
        end
      end else if (w_grant_inst) begin
        r_owner  <= OWN_INST;
        r_wr     <= 1'b0;
        r_size   <= c_size_word;
        r_addr   <= inst_addr;
        r_wdata  <= 32'd0;
        r_starve <= '0;
      end

      if (w_state_nxt == ST_IDLE) begin
        r_drop <= 1'b0;
      end else if ((r_state != ST_IDLE) && (r_owner == OWN_INST) && flush) begin
        r_drop <= 1'b1;
      end
    end
  end

endmodule : mem_bus_arbiter
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter. Directed scenarios
//               for arbitration, starvation, flush, write, stall and reset,
//               followed by randomized traffic compared cycle by cycle with a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        flush, busy;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .flush(flush), .busy(busy),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  // Inputs change 1 time unit after the rising edge; outputs are read 1 unit
  // later, well clear of either clock edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_size = 0;
    data_addr = 0; data_wdata = 0; flush = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    inst_req = 1; data_req = 1; bus_data_ok = 1;
    rst = 1'b1;
    next_cycle();
    #1;
    n_checks++;
    if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, bus_req, busy} !== 6'b0)
      $display("FAIL reset_outputs: ok/req/busy=%b expected 000000",
               {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, bus_req, busy});
    else n_pass++;
    n_checks++;
    if ({bus_wr, bus_size, bus_addr, bus_wdata} !== 67'd0)
      $display("FAIL reset_fields: addr=%h wdata=%h expected 0", bus_addr, bus_wdata);
    else n_pass++;
    clear_inputs();
    next_cycle();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_simultaneous();
    do_reset();
    inst_req = 1; inst_addr = 32'h0000_1000;
    data_req = 1; data_addr = 32'h0000_2004; data_size = 2'd2;
    #1;
    n_checks++;
    if ({data_addr_ok, inst_addr_ok} !== 2'b10)
      $display("FAIL sim_grant: data/inst addr_ok=%b expected 10", {data_addr_ok, inst_addr_ok});
    else n_pass++;
    next_cycle();
    data_req = 0; bus_addr_ok = 1;
    #1;
    n_checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h0000_2004)
      $display("FAIL sim_bus: bus_req=%b bus_addr=%h expected 1/00002004", bus_req, bus_addr);
    else n_pass++;
    next_cycle();
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hCAFE_0001;
    #1;
    n_checks++;
    if ({data_data_ok, inst_addr_ok, data_rdata} !== {2'b10, 32'hCAFE_0001})
      $display("FAIL sim_done: data_ok=%b inst_addr_ok=%b rdata=%h expected 1/0/cafe0001",
               data_data_ok, inst_addr_ok, data_rdata);
    else n_pass++;
    next_cycle();
    bus_data_ok = 0;
    #1;
    n_checks++;
    if (inst_addr_ok !== 1'b1)
      $display("FAIL sim_inst_after: inst_addr_ok=%b expected 1", inst_addr_ok);
    else n_pass++;
    clear_inputs();
    do_reset();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_starvation();
    bit exp_seq [6] = '{1, 1, 1, 1, 0, 1};  // 1 = data grant
    bit got_seq [6];
    int ngr = 0;
    do_reset();
    inst_req = 1; data_req = 1; bus_addr_ok = 1; bus_data_ok = 1;
    for (int c = 0; c < 60 && ngr < 6; c++) begin
      #1;
      if (data_addr_ok) begin got_seq[ngr] = 1; ngr++; end
      else if (inst_addr_ok) begin got_seq[ngr] = 0; ngr++; end
      next_cycle();
    end
    n_checks++;
    if (ngr != 6) $display("FAIL starve_timeout: grants=%0d expected 6", ngr);
    else n_pass++;
    for (int i = 0; i < ngr; i++) begin
      n_checks++;
      if (got_seq[i] !== exp_seq[i])
        $display("FAIL starve_grant%0d: data_grant=%b expected %b", i, got_seq[i], exp_seq[i]);
      else n_pass++;
    end
    clear_inputs();
    do_reset();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush();
    int seen_ok = 0;
    do_reset();
    inst_req = 1; inst_addr = 32'h0040_0000;
    next_cycle();                            // REQ
    inst_req = 0; bus_addr_ok = 1;
    next_cycle();                            // WAIT
    bus_addr_ok = 0; flush = 1;
    #1; seen_ok += inst_data_ok;
    next_cycle();
    flush = 0;
    #1; seen_ok += inst_data_ok;
    next_cycle();
    bus_data_ok = 1; bus_rdata = 32'hDEAD_BEEF;
    #1; seen_ok += inst_data_ok;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL flush_busy_wait: busy=%b expected 1", busy);
    else n_pass++;
    next_cycle();
    bus_data_ok = 0;
    #1; seen_ok += inst_data_ok;
    n_checks++;
    if (seen_ok != 0 || busy !== 1'b0)
      $display("FAIL flush_drop: inst_data_ok pulses=%0d busy=%b expected 0/0", seen_ok, busy);
    else n_pass++;
    inst_req = 1; inst_addr = 32'h0040_0004;
    #1;
    n_checks++;
    if (inst_addr_ok !== 1'b1) $display("FAIL flush_regrant: inst_addr_ok=%b expected 1", inst_addr_ok);
    else n_pass++;
    next_cycle();
    inst_req = 0; bus_addr_ok = 1;
    next_cycle();
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h2402_0001;
    #1;
    n_checks++;
    if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h2402_0001)
      $display("FAIL flush_next_fetch: inst_data_ok=%b rdata=%h expected 1/24020001",
               inst_data_ok, inst_rdata);
    else n_pass++;
    next_cycle();
    clear_inputs();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_write();
    int pulses = 0;
    do_reset();
    data_req = 1; data_wr = 1; data_size = 2'd2;
    data_addr = 32'h8000_0010; data_wdata = 32'h1234_5678;
    next_cycle();
    data_req = 0; data_wr = 0; data_addr = 0; data_wdata = 0; bus_addr_ok = 1;
    #1;
    n_checks++;
    if ({bus_req, bus_wr, bus_size, bus_addr, bus_wdata} !== {1'b1, 1'b1, 2'd2, 32'h8000_0010, 32'h1234_5678})
      $display("FAIL write_fields: req=%b wr=%b size=%0d addr=%h wdata=%h expected 1/1/2/80000010/12345678",
               bus_req, bus_wr, bus_size, bus_addr, bus_wdata);
    else n_pass++;
    next_cycle();
    bus_addr_ok = 0; bus_data_ok = 1;
    for (int c = 0; c < 4; c++) begin
      #1; pulses += data_data_ok;
      next_cycle();
    end
    n_checks++;
    if (pulses != 1) $display("FAIL write_done: data_data_ok pulses=%0d expected 1", pulses);
    else n_pass++;
    clear_inputs();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stall();
    int bad = 0;
    do_reset();
    data_req = 1; data_size = 2'd1; data_addr = 32'h0000_3002;
    next_cycle();
    data_req = 0; data_addr = 32'hFFFF_FFFF; bus_data_ok = 1;   // must be ignored in REQ
    for (int c = 0; c < 5; c++) begin
      #1;
      if (bus_req !== 1'b1 || bus_addr !== 32'h0000_3002 || bus_size !== 2'd1 ||
          bus_wr !== 1'b0 || data_data_ok !== 1'b0) bad++;
      next_cycle();
    end
    n_checks++;
    if (bad != 0) $display("FAIL stall_stable: unstable cycles=%0d expected 0", bad);
    else n_pass++;
    bus_data_ok = 0; bus_addr_ok = 1;
    next_cycle();
    bus_addr_ok = 0; bus_data_ok = 1;
    #1;
    n_checks++;
    if ({bus_req, data_data_ok} !== 2'b01)
      $display("FAIL stall_done: bus_req=%b data_ok=%b expected 0/1", bus_req, data_data_ok);
    else n_pass++;
    next_cycle();
    clear_inputs();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_midflight_reset();
    int stray = 0;
    do_reset();
    data_req = 1; data_addr = 32'h0000_0100;
    next_cycle();
    data_req = 0; bus_addr_ok = 1;
    next_cycle();                           // WAIT
    bus_addr_ok = 0;
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus_req, busy} !== 2'b00)
      $display("FAIL midreset_async: bus_req=%b busy=%b expected 0/0", bus_req, busy);
    else n_pass++;
    next_cycle();
    rst = 1'b0; bus_data_ok = 1;
    for (int c = 0; c < 3; c++) begin
      #1; stray += inst_data_ok + data_data_ok;
      next_cycle();
    end
    n_checks++;
    if (stray != 0) $display("FAIL midreset_stray: data_ok pulses=%0d expected 0", stray);
    else n_pass++;
    clear_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: at most one transaction in flight, described by an
  // "in flight" flag, an "address accepted" flag and the captured request.
  task automatic test_random();
    bit        m_active = 0, m_acc = 0, m_data = 0, m_drop = 0;
    bit        m_wr = 0;
    bit [1:0]  m_size = 0;
    bit [31:0] m_addr = 0, m_wdata = 0;
    int        m_starve = 0;
    bit [5:0]  exp_v, got_v;
    int        bad_v = 0, bad_f = 0;
    bit        g_data, g_inst;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      inst_req    = ($urandom_range(0, 9) < 6);
      data_req    = ($urandom_range(0, 9) < 6);
      inst_addr   = $urandom;
      data_addr   = $urandom;
      data_wr     = $urandom_range(0, 1);
      data_size   = 2'($urandom_range(0, 2));
      data_wdata  = $urandom;
      flush       = ($urandom_range(0, 7) == 0);
      bus_addr_ok = $urandom_range(0, 1);
      bus_data_ok = $urandom_range(0, 1);
      bus_rdata   = $urandom;
      #1;
      exp_v  = '0;
      g_data = 0; g_inst = 0;
      if (!m_active) begin
        if (data_req && !(inst_req && !flush && m_starve == STARVE_MAX)) g_data = 1;
        else if (inst_req && !flush) g_inst = 1;
        exp_v[5] = g_inst;
        exp_v[4] = g_data;
      end else if (!m_acc) begin
        exp_v[1] = 1;
      end else if (bus_data_ok) begin
        exp_v[3] = !m_data && !(m_drop || flush);
        exp_v[2] = m_data;
      end
      exp_v[0] = m_active;
      got_v = {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, bus_req, busy};
      if (got_v !== exp_v) begin
        bad_v++;
        if (bad_v <= 5) $display("FAIL rand_ctl cycle %0d: outputs=%b expected %b", c, got_v, exp_v);
      end
      if (exp_v[1] && ({bus_wr, bus_size, bus_addr, bus_wdata} !== {m_wr, m_size, m_addr, m_wdata})) begin
        bad_f++;
        if (bad_f <= 5) $display("FAIL rand_fields cycle %0d: addr=%h wdata=%h expected %h/%h",
                                 c, bus_addr, bus_wdata, m_addr, m_wdata);
      end
      // advance the model across the coming clock edge
      if (g_data) begin
        m_active = 1; m_acc = 0; m_data = 1; m_drop = 0;
        m_wr = data_wr; m_size = data_size; m_addr = data_addr; m_wdata = data_wdata;
        m_starve = inst_req ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
      end else if (g_inst) begin
        m_active = 1; m_acc = 0; m_data = 0; m_drop = 0;
        m_wr = 0; m_size = 2'd2; m_addr = inst_addr; m_wdata = 0;
        m_starve = 0;
      end else if (m_active) begin
        if (!m_data && flush) m_drop = 1;
        if (!m_acc) m_acc = bus_addr_ok;
        else if (bus_data_ok) begin m_active = 0; m_drop = 0; end
      end
      next_cycle();
    end
    n_checks++;
    if (bad_v != 0) $display("FAIL rand_ctl_total: mismatching cycles=%0d expected 0", bad_v);
    else n_pass++;
    n_checks++;
    if (bad_f != 0) $display("FAIL rand_fields_total: mismatching cycles=%0d expected 0", bad_f);
    else n_pass++;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #2;
    test_reset();
    test_simultaneous();
    test_starvation();
    test_flush();
    test_write();
    test_stall();
    test_midflight_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mem_bus_arbiter
`default_nettype wire
